// File: rtl/conc_obs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conc_obs_pkg
// Purpose : Shared types and helpers for the observe-capture path.
//           Serializer state enum, default record geometry, record layout,
//           and a 16-bit saturating increment.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package conc_obs_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned WORD_W_DEF = 32;
  // Data words per record (the header stamp word is extra).
  localparam int unsigned WPR        = DATA_W_DEF / WORD_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DAT  = 2'd2
  } state_e;

  // Buffered record: stamp sits above the data in the packed FIFO word.
  typedef struct packed {
    logic [WORD_W_DEF-1:0] stamp;
    logic [DATA_W_DEF-1:0] data;
  } rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : conc_sync_fifo
// Purpose : Generic single-clock FIFO with first-word fall-through read port.
//           A push while full is accepted when a pop happens on the same edge.
// Ports   : clk_i    - clock
//           rst_ni   - async active-low reset (empties the FIFO)
//           push_i   - write strobe, wdata_i - write data
//           pop_i    - read strobe (ignored while empty)
//           rdata_o  - head entry, valid while !empty_o
//           full_o / empty_o / count_o - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module conc_sync_fifo #(
  parameter  int unsigned WIDTH = 160,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop, do_push;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // The pop frees a slot on the same edge, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/conc_obs_capture.sv
`default_nettype none
// ============================================================================
// Module  : conc_obs_capture
// Purpose : Samples observed DUT output on each obs strobe, stamps it with
//           the cycle count, buffers it and streams it out as a
//           header word followed by DATA_W/WORD_W data words (MS first).
// Ports   : clk_i, rst_ni         - clock, async active-low reset
//           obs_i, obs_data_i     - capture strobe and sampled data
//           clr_i                 - clears ovf_o / drop_cnt_o
//           m_valid_o, m_ready_i, m_data_o, m_last_o - word stream
//           ovf_o                 - sticky drop flag
//           drop_cnt_o            - saturating dropped-sample count
// Revision: 1.0 - initial release
// ============================================================================
module conc_obs_capture
  import conc_obs_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              obs_i,
  input  logic [DATA_W-1:0] obs_data_i,
  input  logic              clr_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              ovf_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned IW     = $clog2(NWORDS + 1);
  localparam int unsigned AW     = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]   cyc_q;
  logic                ovf_q;
  logic [15:0]         drop_q;

  logic [WORD_W+DATA_W-1:0] head;
  logic                     fifo_full, fifo_empty;
  logic [AW:0]              fifo_count;
  logic                     pop, push, drop, more;

  // Pop only on the handshake of the final data word of a record.
  assign pop  = (state_q == DAT) && m_ready_i && (idx_q == IW'(NWORDS));
  assign push = obs_i && (!fifo_full || pop);
  assign drop = obs_i && fifo_full && !pop;
  // Anything left after this edge's pop, counting a same-edge push?
  assign more = (fifo_count > (AW+1)'(1)) || push;

  conc_sync_fifo #(
    .WIDTH (WORD_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({cyc_q, obs_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_q + WORD_W'(1);
      // A drop on the clear edge wins: the count restarts at one.
      if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= clr_i ? 16'd1 : sat_inc16(drop_q);
      end else if (clr_i) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = HDR;
      end
      HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = head[DATA_W +: WORD_W];
        if (m_ready_i) begin
          state_d = DAT;
          idx_d   = IW'(1);
        end
      end
      DAT: begin
        m_valid_o = 1'b1;
        m_last_o  = (idx_q == IW'(NWORDS));
        // idx 1 selects the most significant data word.
        for (int unsigned w = 0; w < NWORDS; w++) begin
          if (idx_q == IW'(w + 1)) m_data_o = head[DATA_W-1-w*WORD_W -: WORD_W];
        end
        if (m_ready_i) begin
          if (m_last_o) begin
            state_d = more ? HDR : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_conc_obs_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_conc_obs_capture
// Purpose : Self-checking bench for conc_obs_capture: directed scenarios and
//           a randomized run against a record/word-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conc_obs_capture;

  localparam int NW    = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         obs = 1'b0;
  logic [127:0] obs_data = '0;
  logic         clr = 1'b0;
  logic         m_ready = 1'b0;
  logic         m_valid, m_last, ovf;
  logic [31:0]  m_data;
  logic [15:0]  drop_cnt;

  conc_obs_capture dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .obs_i      (obs),
    .obs_data_i (obs_data),
    .clr_i      (clr),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .ovf_o      (ovf),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding stream words, buffered record count,
  // position within the head record (0 = header), stream-valid flag.
  logic [31:0] wq[$];
  logic [31:0] hs_log[$];
  int          recs, pos, mdrop;
  bit          ev, movf;
  logic [31:0] mcyc;

  task automatic model_clear();
    wq.delete();
    recs = 0; pos = 0; mdrop = 0; ev = 0; movf = 0; mcyc = '0;
  endtask

  // Entered and left at a negedge: check, drive, clock, advance the model.
  task automatic step(input bit o, input logic [127:0] d, input bit r, input bit c);
    bit hs, pop, drp;
    int prev;
    check_eq("valid", m_valid, ev);
    if (ev) begin
      if (wq.size() == 0) check_eq("model_words", 0, 1);
      else begin
        check_eq("data", m_data, wq[0]);
        check_eq("last", m_last, pos == NW);
      end
    end
    check_eq("ovf", ovf, movf);
    check_eq("drop_cnt", drop_cnt, mdrop);
    obs = o; obs_data = d; m_ready = r; clr = c;
    if (m_valid && r) hs_log.push_back(m_data);
    @(posedge clk);
    hs = ev && r;
    pop = 0;
    if (hs && wq.size() > 0) begin
      void'(wq.pop_front());
      if (pos == NW) begin pos = 0; pop = 1; end
      else pos++;
    end
    prev = recs;
    if (pop) recs--;
    drp = 0;
    if (o) begin
      if (recs < DEPTH) begin
        wq.push_back(mcyc);
        for (int w = 0; w < NW; w++) wq.push_back(d[127-32*w -: 32]);
        recs++;
      end else drp = 1;
    end
    if (drp) begin
      movf = 1;
      mdrop = c ? 1 : ((mdrop == 65535) ? 65535 : mdrop + 1);
    end else if (c) begin
      movf = 0; mdrop = 0;
    end
    if (!ev) ev = (prev > 0);
    else if (pop) ev = (recs > 0);
    mcyc = mcyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; obs = 0; m_ready = 0; clr = 0;
    #1;
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_data", m_data, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_drop", drop_cnt, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hs_log.delete();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [31:0]  t1_exp [5] = '{32'h3, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // 1: single record, sink always ready.
    do_reset();
    repeat (3) step(0, '0, 1, 0);
    step(1, D1, 1, 0);
    for (int i = 0; i < 20 && hs_log.size() < 5; i++) step(0, '0, 1, 0);
    check_eq("t1_cnt", hs_log.size(), 5);
    for (int i = 0; i < 5 && i < hs_log.size(); i++) check_eq("t1_word", hs_log[i], t1_exp[i]);

    // 2: backpressure holds the header stable.
    do_reset();
    repeat (3) step(0, '0, 0, 0);
    step(1, D1, 0, 0);
    for (int i = 0; i < 5 && !m_valid; i++) step(0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check_eq("t2_hold_v", m_valid, 1);
      check_eq("t2_hold_d", m_data, 32'h3);
      step(0, '0, 0, 0);
    end
    for (int i = 0; i < 20 && hs_log.size() < 5; i++) step(0, '0, 1, 0);
    check_eq("t2_cnt", hs_log.size(), 5);
    if (hs_log.size() >= 5) check_eq("t2_last", hs_log[4], 32'hCCDDEEFF);

    // 3: overflow with 12 strobes into an 8-deep FIFO.
    do_reset();
    repeat (12) step(1, rnd128(), 0, 0);
    check_eq("t3_ovf", ovf, 1);
    check_eq("t3_drop", drop_cnt, 4);

    // 4: clear, then drain; stamps 0..7 in order.
    step(0, '0, 0, 1);
    check_eq("t4_ovf", ovf, 0);
    check_eq("t4_drop", drop_cnt, 0);
    for (int i = 0; i < 80 && hs_log.size() < 40; i++) step(0, '0, 1, 0);
    check_eq("t4_cnt", hs_log.size(), 40);
    for (int i = 0; i < 8 && 5*i < hs_log.size(); i++) check_eq("t4_stamp", hs_log[5*i], i);

    // 5: push on the last-word pop edge while full.
    do_reset();
    repeat (8) step(1, rnd128(), 0, 0);
    for (int i = 0; i < 20 && !(ev && pos == NW); i++) step(0, '0, 1, 0);
    check_eq("t5_at_last", m_last, 1);
    step(1, rnd128(), 1, 0);
    check_eq("t5_drop", drop_cnt, 0);
    check_eq("t5_ovf", ovf, 0);
    check_eq("t5_nogap", m_valid, 1);
    check_eq("t5_next_hdr", m_data, 1);
    for (int i = 0; i < 60 && ev; i++) step(0, '0, 1, 0);
    check_eq("t5_drained", m_valid, 0);

    // 6: reset mid-record, stamps restart.
    do_reset();
    step(1, D1, 1, 0);
    for (int i = 0; i < 10 && hs_log.size() < 2; i++) step(0, '0, 1, 0);
    do_reset();
    step(1, rnd128(), 1, 0);
    for (int i = 0; i < 10 && hs_log.size() < 1; i++) step(0, '0, 1, 0);
    check_eq("t6_cnt", hs_log.size() >= 1, 1);
    if (hs_log.size() >= 1) check_eq("t6_stamp", hs_log[0], 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

    // Randomized: varying obs density and sink readiness.
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      int po, pr;
      po = (seg == 0) ? 20 : (seg == 1) ? 60 : 35;
      pr = (seg == 0) ? 90 : (seg == 1) ? 30 : 70;
      for (int i = 0; i < 1000; i++)
        step($urandom_range(0, 99) < po, rnd128(), $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
